// File: rtl/dot_accum_ctrl.sv
// Feeds beats of a vector into a fixed-latency dot-product engine and accumulates
// the per-beat engine results into one signed sum per vector, with a valid/ready output.
module dot_accum_ctrl #(
  parameter  int SIZEA  = 4,
  parameter  int SIZEB  = 4,
  parameter  int DOT    = 16,
  parameter  int LAT    = 5,
  parameter  int MAXLEN = 64,
  localparam int PW     = $clog2(DOT) + SIZEA + SIZEB - 1,
  localparam int ACCW   = PW + $clog2(MAXLEN),
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LW-1:0]          cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZEA*DOT-1:0]   in_a,
  input  logic [SIZEB*DOT-1:0]   in_b,
  output logic [SIZEA*DOT-1:0]   eng_a,
  output logic [SIZEB*DOT-1:0]   eng_b,
  input  logic signed [PW-1:0]   eng_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic [15:0]            out_idx,
  output logic                   busy
);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t                 state_q;
  logic [LW-1:0]          cnt_q, cnt_d, len_q, len_d;
  logic [LAT:0]           tv_q, tf_q, tl_q;
  logic [LAT:0]           tv_d, tf_d, tl_d;
  logic signed [ACCW-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic                   acc_act_q, acc_act_d;
  logic                   out_valid_q, out_valid_d;
  logic [15:0]            idx_q, idx_d;
  logic [SIZEA*DOT-1:0]   eng_a_q;
  logic [SIZEB*DOT-1:0]   eng_b_q;

  logic [LW-1:0]          cfg_eff, cur_len;
  logic                   first_beat, next_last, last_in_flight, accept;
  logic                   emerge_v, emerge_f, emerge_l;
  logic signed [ACCW-1:0] dout_ext, sum;

  always_comb begin
    if (cfg_len == '0)                cfg_eff = LW'(1);
    else if (cfg_len > LW'(MAXLEN))   cfg_eff = LW'(MAXLEN);
    else                              cfg_eff = cfg_len;
  end

  assign first_beat     = (cnt_q == '0);
  assign cur_len        = first_beat ? cfg_eff : len_q;
  assign next_last      = (cnt_q == cur_len - LW'(1));
  assign last_in_flight = |(tv_q & tl_q);

  // A last beat is only admitted when its result is guaranteed a free output slot.
  assign in_ready = (state_q == ST_RUN) &&
                    !(next_last && (last_in_flight || (out_valid_q && !out_ready)));
  assign accept   = in_valid && in_ready;

  assign emerge_v = tv_q[LAT];
  assign emerge_f = tf_q[LAT];
  assign emerge_l = tl_q[LAT];
  assign dout_ext = ACCW'(eng_dout);
  assign sum      = emerge_f ? dout_ext : acc_q + dout_ext;

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_d       = acc_q;
    acc_act_d   = acc_act_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    idx_d       = idx_q;
    tv_d        = {tv_q[LAT-1:0], accept};
    tf_d        = {tf_q[LAT-1:0], accept && first_beat};
    tl_d        = {tl_q[LAT-1:0], accept && next_last};

    if (accept) begin
      if (first_beat) len_d = cfg_eff;
      cnt_d = next_last ? '0 : cnt_q + LW'(1);
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      idx_d       = idx_q + 16'd1;
    end

    if (emerge_v) begin
      if (emerge_l) begin
        out_data_d  = sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
        acc_act_d   = 1'b0;
      end else begin
        acc_d       = sum;
        acc_act_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      len_q       <= LW'(1);
      tv_q        <= '0;
      tf_q        <= '0;
      tl_q        <= '0;
      acc_q       <= '0;
      acc_act_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      idx_q       <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
    end else begin
      state_q     <= ST_RUN;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tv_q        <= tv_d;
      tf_q        <= tf_d;
      tl_q        <= tl_d;
      acc_q       <= acc_d;
      acc_act_q   <= acc_act_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      idx_q       <= idx_d;
      if (accept) begin
        eng_a_q <= in_a;
        eng_b_q <= in_b;
      end
    end
  end

  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign busy      = (|tv_q) || acc_act_q || out_valid_q;

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(emerge_v && emerge_l && out_valid_q && !out_ready))
    else $error("result arrived while previous result still held");

endmodule

// File: doc/dot_accum_ctrl.md
DOT_ACCUM_CTRL -- requirements
Module: dot_accum_ctrl

Interface
REQ-001 Parameter SIZEA, default 4: operand A element width, sign-magnitude.
REQ-002 Parameter SIZEB, default 4: operand B element width, sign-magnitude.
REQ-003 Parameter DOT, default 16: elements per beat, equal to the dot-product engine width.
REQ-004 Parameter LAT, default 5, legal 1..16: engine latency in cycles from eng_a/eng_b to eng_dout.
REQ-005 Parameter MAXLEN, default 64: maximum beats per vector.
REQ-006 Derived PW = $clog2(DOT)+SIZEA+SIZEB-1 (engine result width); ACCW = PW+$clog2(MAXLEN).
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 cfg_len  in  $clog2(MAXLEN+1)  beats per vector; sampled only on the first beat of each vector.
REQ-010 in_valid  in  1  input beat valid.
REQ-011 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-012 in_a / in_b  in  SIZEA*DOT / SIZEB*DOT  operand beat.
REQ-013 eng_a / eng_b  out  SIZEA*DOT / SIZEB*DOT  registered operands to the engine.
REQ-014 eng_dout  in  PW  signed engine result.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  result accepted when out_valid && out_ready.
REQ-017 out_data  out  ACCW  signed accumulated vector dot product.
REQ-018 out_idx  out  16  vector sequence number, starting at 0 after reset and wrapping 65535 -> 0.
REQ-019 busy  out  1  high when any beat is in flight, the accumulator is non-empty, or out_valid is high.

Function
REQ-020 On an accepted beat, register in_a/in_b into eng_a/eng_b on the same edge. eng_a/eng_b hold their value when no beat is accepted.
REQ-021 Beat counter: reset 0; increments per accepted beat; returns to 0 after the last beat of a vector.
REQ-022 An accepted beat is first when beat counter = 0, and last when beat counter = eff_len-1.
REQ-023 eff_len = cfg_len latched on the first beat; cfg_len = 0 SHALL be treated as 1; cfg_len > MAXLEN SHALL be clamped to MAXLEN.
REQ-024 Tag pipeline: valid/first/last flags, LAT+1 stages, aligned so that a tag emerges in the cycle when eng_dout holds that beat's result.
REQ-025 Tag pipeline shifts every cycle and is never stalled; the engine is not stallable.
REQ-026 On an emerging valid tag, the accumulator loads sign-extended eng_dout if first, otherwise acc + sign-extended eng_dout. The sum is full width, with no saturation.
REQ-027 On an emerging last tag, out_data and out_valid are loaded on the same edge as the accumulator update, and the accumulator clears to 0.
REQ-028 Latency: a last beat accepted at edge k SHALL raise out_valid after edge k+LAT+1.
REQ-029 in_ready is high, except when the next beat would be last and either a last tag is in flight or (out_valid && !out_ready). in_ready is high otherwise.
REQ-030 in_ready SHALL NOT depend combinationally on in_valid.
REQ-031 Non-last beats of the next vector SHALL be accepted back-to-back while a previous last beat is in flight.
REQ-032 out_valid holds, with out_data and out_idx stable, until out_ready. On handshake, out_valid drops unless a new result loads on the same edge.
REQ-033 out_idx increments on each output handshake.
REQ-034 An emerging last tag while out_valid && !out_ready SHALL be impossible by construction. An assertion SHALL flag it.

Reset
REQ-035 rst_n low asynchronously clears: beat counter, eff_len (to 1), tag pipeline, accumulator, out_valid, out_data, out_idx, and eng_a/eng_b (to 0).
REQ-036 During reset, in_ready = 0.
REQ-037 in_ready rises on the first clk edge after rst_n deasserts.
REQ-038 Reset mid-vector discards all in-flight beats and the partial sum. Late eng_dout values SHALL NOT affect state, because all tags are cleared.

Verification
REQ-039 Single beat: LAT=2, cfg_len=1, engine stub returns 16, out_ready=1 -> out_valid high exactly 3 edges after acceptance, out_data=16, out_idx=0.
REQ-040 Multi-beat: cfg_len=4, stub returns 16,-3,7,0, in_valid continuous -> in_ready stays high, one result with out_data=20.
REQ-041 Backpressure: cfg_len=1, out_ready=0 for 20 cycles, 3 vectors offered -> only the first completes. in_ready is low while it is held. After out_ready=1, results arrive in order with idx 0,1,2 and none lost.
REQ-042 Zero-length config: cfg_len=0 -> every beat is a 1-beat vector. A cfg_len change mid-vector is ignored until the next first beat.
REQ-043 Reset mid-operation: rst_n low after 2 of 4 beats -> no out_valid. The next 4-beat vector (stub returns 1 each) yields out_data=4 with out_idx=0.
REQ-044 Random: random in_valid/out_ready and cfg_len 1..MAXLEN against a real dot_product engine vs a scoreboard -> results match the scoreboard, in order, with no REQ-034 assertion firing.
